ram_acc_engine: RTL and testbench

RAM_ACC_ENGINE -- requirements
Module: ram_acc_engine

---
 rtl/ram_acc_pkg.sv | 20 ++
 rtl/ram_acc_if.sv | 31 +++
 rtl/ram_acc_alu.sv | 27 ++
 rtl/ram_acc_engine.sv | 139 +++++++++++++
 tb/tb_ram_acc_engine.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_acc_pkg.sv
// ram_acc_pkg: shared sizing constants and FSM state type for the RAM
// accumulate engine.
//   ADDR_W  - RAM address width
//   DATA_W  - RAM data width
//   DEPTH   - RAM words (2**ADDR_W)
//   state_t - engine FSM states
package ram_acc_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_acc_if.sv
// ram_acc_if: bus between the accumulate engine and a 2R1W RAM with
// registered reads (read data valid the cycle after its address).
//   master (engine): drives enables, addresses and write data; reads data
//   slave  (RAM)   : the reverse
interface ram_acc_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) ();

  logic              ram_en;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [ADDR_W-1:0] ram_rd_addr1;
  logic [ADDR_W-1:0] ram_rd_addr2;
  logic [DATA_W-1:0] ram_rd_data1;
  logic [DATA_W-1:0] ram_rd_data2;

  modport master (
    output ram_en, ram_wr_en, ram_wr_addr, ram_wr_data,
    output ram_rd_addr1, ram_rd_addr2,
    input  ram_rd_data1, ram_rd_data2
  );

  modport slave (
    input  ram_en, ram_wr_en, ram_wr_addr, ram_wr_data,
    input  ram_rd_addr1, ram_rd_addr2,
    output ram_rd_data1, ram_rd_data2
  );

endinterface

// File: rtl/ram_acc_alu.sv
// ram_acc_alu: combinational element adder.
//   a, b  - operands
//   sum   - result (wrapping, or saturating when RAM_ACC_SAT_EN is defined)
//   carry - carry-out of the unsaturated add
// Build option: RAM_ACC_SAT_EN selects saturation to all-ones on carry.
module ram_acc_alu #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              carry
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide  = {1'b0, a} + {1'b0, b};
    carry = wide[DATA_W];
`ifdef RAM_ACC_SAT_EN
    sum = carry ? '1 : wide[DATA_W-1:0];
`else
    sum = wide[DATA_W-1:0];
`endif
  end

endmodule

// File: rtl/ram_acc_engine.sv
// ram_acc_engine: streams mem[d+k] = mem[a+k] + mem[b+k] for k in 0..len-1
// through a 2R1W registered-read RAM at one element per cycle.
//   clk, rst_n          - clock, async active-low reset
//   start               - launch request, sampled only in IDLE
//   a_base/b_base/d_base- first source A / source B / destination address
//   len                 - element count 0..DEPTH
//   busy                - high outside IDLE
//   done                - one-cycle completion pulse
//   ovf                 - sticky carry-out flag, cleared on accepted start
//   ram                 - RAM bus (ram_acc_if.master)
// Build option: RAM_ACC_SAT_EN (saturating add, handled in ram_acc_alu).
module ram_acc_engine
  import ram_acc_pkg::*;
#(
  parameter int unsigned ADDR_W = ram_acc_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram_acc_pkg::DATA_W,
  parameter int unsigned DEPTH  = ram_acc_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] d_base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  ram_acc_if.master         ram
);

  localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] a_q, b_q, d_q;
  logic              ovf_q;
  logic              accept;
  logic              wr_fire;
  logic [ADDR_W-1:0] idx_lo;
  logic [DATA_W-1:0] sum;
  logic              carry;

  assign idx_lo = idx_q[ADDR_W-1:0];
  assign ovf    = ovf_q;

  ram_acc_alu #(.DATA_W(DATA_W)) u_alu (
    .a     (ram.ram_rd_data1),
    .b     (ram.ram_rd_data2),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= a_base;
        b_q   <= b_base;
        d_q   <= d_base;
        len_q <= (len > LEN_MAX) ? LEN_MAX : len;
        idx_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        // idx holds at len-1 through FLUSH so the last write address is d+idx
        if (state_q == RUN && state_d == RUN) begin
          idx_q <= idx_q + ONE_L;
        end
        if (wr_fire && carry) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    wr_fire          = 1'b0;
    busy             = (state_q != IDLE);
    done             = (state_q == DONE);
    ram.ram_en       = 1'b0;
    ram.ram_wr_en    = 1'b0;
    ram.ram_wr_addr  = '0;
    ram.ram_wr_data  = '0;
    ram.ram_rd_addr1 = '0;
    ram.ram_rd_addr2 = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        ram.ram_en       = 1'b1;
        ram.ram_rd_addr1 = a_q + idx_lo;
        ram.ram_rd_addr2 = b_q + idx_lo;
        // element idx-1's read data arrives now; write it back
        if (idx_q != '0) begin
          wr_fire         = 1'b1;
          ram.ram_wr_en   = 1'b1;
          ram.ram_wr_addr = d_q + idx_lo - ONE_A;
          ram.ram_wr_data = sum;
        end
        if (idx_q == len_q - ONE_L) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        wr_fire         = 1'b1;
        ram.ram_en      = 1'b1;
        ram.ram_wr_en   = 1'b1;
        ram.ram_wr_addr = d_q + idx_lo;
        ram.ram_wr_data = sum;
        state_d         = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_acc_engine.sv
// tb_ram_acc_engine: directed bench for ram_acc_engine with a behavioural
// 64x8 registered-read 2R1W RAM. Build option: RAM_ACC_SAT_EN.
module tb_ram_acc_engine;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] a_base, b_base, d_base;
  logic [6:0] len;
  logic       busy, done, ovf;

  logic       tb_we;
  logic [5:0] tb_wa;
  logic [7:0] tb_wd;
  logic [7:0] mem [64];

  int checks = 0;
  int errors = 0;
  int en_cnt;
  int rd_q[$];
  int wr_q[$];
  int cyc;
  int done_seen;

  ram_acc_if #(.ADDR_W(6), .DATA_W(8)) ram_bus ();

  ram_acc_engine #(.ADDR_W(6), .DATA_W(8), .DEPTH(64)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_base (a_base),
    .b_base (b_base),
    .d_base (d_base),
    .len    (len),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .ram    (ram_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered reads; writes land via NBA so a same-cycle read sees old data
  always @(posedge clk) begin
    if (ram_bus.ram_en) begin
      ram_bus.ram_rd_data1 <= mem[ram_bus.ram_rd_addr1];
      ram_bus.ram_rd_data2 <= mem[ram_bus.ram_rd_addr2];
    end
    if (ram_bus.ram_en && ram_bus.ram_wr_en) mem[ram_bus.ram_wr_addr] <= ram_bus.ram_wr_data;
    if (tb_we) mem[tb_wa] <= tb_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic run_op(input logic [5:0] a, input logic [5:0] b, input logic [5:0] d,
                        input logic [6:0] n, input int pulse_cyc, input int rst_cyc,
                        output int cycles);
    rd_q.delete();
    wr_q.delete();
    en_cnt = 0;
    @(negedge clk);
    a_base = a; b_base = b; d_base = d; len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_base = ~a; b_base = ~b; d_base = ~d; len = 7'd3;
    cycles = 1;
    while (1) begin
      if (cycles == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_wr_en", ram_bus.ram_wr_en, 1'b0);
        check("rst_en", ram_bus.ram_en, 1'b0);
        break;
      end
      if (ram_bus.ram_en) begin
        en_cnt++;
        rd_q.push_back(int'(ram_bus.ram_rd_addr1));
      end
      if (ram_bus.ram_wr_en) wr_q.push_back(int'(ram_bus.ram_wr_addr));
      if (done) break;
      if (cycles >= 150) begin
        check("done_timeout", done, 1'b1);
        break;
      end
      start = (cycles == pulse_cyc);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
  endtask

  task automatic after_done();
    @(negedge clk);
    check("done_width", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_en", ram_bus.ram_en, 1'b0);
    check("idle_wr_addr", ram_bus.ram_wr_addr, 6'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    a_base = '0; b_base = '0; d_base = '0; len = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_ovf", ovf, 1'b0);
    check("reset_en", ram_bus.ram_en, 1'b0);
    check("reset_wr_en", ram_bus.ram_wr_en, 1'b0);
    check("reset_rd_addr1", ram_bus.ram_rd_addr1, 6'd0);
    check("reset_wr_data", ram_bus.ram_wr_data, 8'd0);
    rst_n = 1'b1;

    // basic 4-element add
    for (int unsigned i = 0; i < 4; i++) begin
      poke(6'(i), 8'(i + 1));
      poke(6'(8 + i), 8'(10 * (i + 1)));
    end
    run_op(6'd0, 6'd8, 6'd16, 7'd4, -1, -1, cyc);
    check("t1_cycles", cyc, 6);
    check("t1_rd0", rd_q[0], 0);
    check("t1_rd3", rd_q[3], 3);
    check("t1_wr_cnt", wr_q.size(), 4);
    check("t1_wr0", wr_q[0], 16);
    check("t1_wr3", wr_q[3], 19);
    after_done();
    check("t1_m16", mem[16], 8'd11);
    check("t1_m17", mem[17], 8'd22);
    check("t1_m18", mem[18], 8'd33);
    check("t1_m19", mem[19], 8'd44);
    check("t1_ovf", ovf, 1'b0);

    // destination one ahead of source A: same-cycle read/write of one word
    poke(6'd40, 8'd1); poke(6'd41, 8'd2); poke(6'd42, 8'd3);
    poke(6'd44, 8'd10); poke(6'd45, 8'd10); poke(6'd46, 8'd10);
    run_op(6'd40, 6'd44, 6'd41, 7'd3, -1, -1, cyc);
    check("ov_cycles", cyc, 5);
    after_done();
    check("ov_m41", mem[41], 8'd11);
    check("ov_m42", mem[42], 8'd12);
    check("ov_m43", mem[43], 8'd13);

    // carry-out element
    poke(6'd5, 8'hF0); poke(6'd6, 8'h20);
    run_op(6'd5, 6'd6, 6'd7, 7'd1, -1, -1, cyc);
    check("sat_cycles", cyc, 3);
    after_done();
`ifdef RAM_ACC_SAT_EN
    check("sat_m7", mem[7], 8'hFF);
`else
    check("sat_m7", mem[7], 8'h10);
`endif
    check("sat_ovf", ovf, 1'b1);

    // zero length
    run_op(6'd0, 6'd8, 6'd16, 7'd0, -1, -1, cyc);
    check("z_cycles", cyc, 1);
    check("z_en_cnt", en_cnt, 0);
    check("z_ovf", ovf, 1'b0);
    after_done();

    // start pulse mid-run is ignored
    for (int unsigned i = 4; i < 8; i++) begin
      poke(6'(i), 8'(i + 1));
      poke(6'(8 + i), 8'(10 * (i + 1)));
    end
    run_op(6'd0, 6'd8, 6'd20, 7'd8, 2, -1, cyc);
    check("p_cycles", cyc, 10);
    check("p_wr_cnt", wr_q.size(), 8);
    check("p_wr0", wr_q[0], 20);
    check("p_wr7", wr_q[7], 27);
    after_done();
    check("p_m20", mem[20], 8'd11);
    check("p_m27", mem[27], 8'd88);
    check("p_no_restart", busy, 1'b0);

    // reset mid-run
    poke(6'd50, 8'hAA);
    run_op(6'd0, 6'd8, 6'd48, 7'd8, -1, 3, cyc);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || ram_bus.ram_wr_en) done_seen++;
    end
    check("r_no_done", done_seen, 0);
    check("r_m48", mem[48], 8'd11);
    check("r_m50", mem[50], 8'hAA);
    check("r_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    run_op(6'd0, 6'd8, 6'd24, 7'd4, -1, -1, cyc);
    check("r2_cycles", cyc, 6);
    after_done();
    check("r2_m24", mem[24], 8'd11);
    check("r2_m27", mem[27], 8'd44);

    // wrap-around addressing
    poke(6'd62, 8'h05); poke(6'd63, 8'h06); poke(6'd0, 8'h07); poke(6'd1, 8'h08);
    poke(6'd30, 8'h10); poke(6'd31, 8'h11); poke(6'd32, 8'h12); poke(6'd33, 8'h13);
    run_op(6'd62, 6'd30, 6'd60, 7'd4, -1, -1, cyc);
    check("w_cycles", cyc, 6);
    check("w_rd0", rd_q[0], 62);
    check("w_rd1", rd_q[1], 63);
    check("w_rd2", rd_q[2], 0);
    check("w_rd3", rd_q[3], 1);
    check("w_wr2", wr_q[2], 62);
    check("w_wr3", wr_q[3], 63);
    after_done();
    check("w_m60", mem[60], 8'h15);
    check("w_m61", mem[61], 8'h17);
    check("w_m62", mem[62], 8'h19);
    check("w_m63", mem[63], 8'h1B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
